// File: rtl/dac_arbiter_pkg.sv
// Shared firmware constants for the DAC SPI path.
// Used by the control loop and the DAC arbiter.
package dac_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  localparam logic REQ_CTRL = 1'b0;
  localparam logic REQ_CPU  = 1'b1;

  localparam logic [3:0] DAC_REG_CODE = 4'h2;

endpackage

// File: rtl/dac_arbiter.sv
// Two-requester arbiter in front of the shared DAC SPI master.
// Requester 0 has priority, bounded by a starvation limit for requester 1.
module dac_arbiter
  import dac_arbiter_pkg::*;
#(
  parameter int DAC_WID    = 24,
  parameter int STARVE_LIM = 4,
  parameter int STARVE_WID = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_0,
  input  logic [DAC_WID-1:0] to_dac_0,
  input  logic               ss_0,
  output logic [DAC_WID-1:0] from_dac_0,
  output logic               finished_0,
  input  logic               arm_1,
  input  logic [DAC_WID-1:0] to_dac_1,
  input  logic               ss_1,
  output logic [DAC_WID-1:0] from_dac_1,
  output logic               finished_1,
  output logic               master_arm,
  output logic [DAC_WID-1:0] master_to_slave,
  output logic               master_ss,
  input  logic [DAC_WID-1:0] master_from_slave,
  input  logic               master_finished
);

  localparam logic [STARVE_WID-1:0] LIM =
    STARVE_WID'(STARVE_LIM);

  state_t                state, state_nx;
  logic                  g, g_nx;
  logic [STARVE_WID-1:0] starve, starve_nx;
  logic [DAC_WID-1:0]    word, word_nx;
  logic                  arm_g;
  logic                  pick_cpu;

  assign arm_g    = g ? arm_1 : arm_0;
  assign pick_cpu = arm_1 && (!arm_0 || starve == LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      g      <= REQ_CTRL;
      starve <= '0;
      word   <= '0;
    end else begin
      state  <= state_nx;
      g      <= g_nx;
      starve <= starve_nx;
      word   <= word_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    starve_nx = starve;
    word_nx   = word;
    unique case (state)
      ST_IDLE: begin
        if (arm_0 || arm_1) begin
          state_nx = ST_GRANT;
          unique case (1'b1)
            pick_cpu: begin
              g_nx      = REQ_CPU;
              word_nx   = to_dac_1;
              starve_nx = '0;
            end
            default: begin
              g_nx    = REQ_CTRL;
              word_nx = to_dac_0;
              // count only grants that made requester 1 wait
              if (arm_1 && starve != LIM)
                starve_nx = starve + STARVE_WID'(1);
            end
          endcase
        end
      end
      ST_GRANT: begin
        if (!arm_g) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!master_finished) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign master_to_slave = word;

  always_comb begin
    master_arm = 1'b0;
    master_ss  = 1'b0;
    finished_0 = 1'b0;
    finished_1 = 1'b0;
    from_dac_0 = '0;
    from_dac_1 = '0;
    if (state == ST_GRANT) begin
      master_arm = 1'b1;
      if (g == REQ_CPU) begin
        master_ss  = ss_1;
        finished_1 = master_finished;
        from_dac_1 = master_from_slave;
      end else begin
        master_ss  = ss_0;
        finished_0 = master_finished;
        from_dac_0 = master_from_slave;
      end
    end
  end

endmodule

// File: tb/tb_dac_arbiter.sv
// Directed scoreboard bench for dac_arbiter.
// Expected grants are queued when requests are raised.
module tb_dac_arbiter;
  import dac_arbiter_pkg::*;

  logic        clk, rst;
  logic        arm_0, arm_1, ss_0, ss_1;
  logic [23:0] to_dac_0, to_dac_1;
  logic [23:0] from_dac_0, from_dac_1;
  logic        finished_0, finished_1;
  logic        master_arm, master_ss, master_finished;
  logic [23:0] master_to_slave, master_from_slave;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          g;
    logic [23:0] w;
    int          lat;
  } exp_t;
  exp_t sb[$];

  dac_arbiter #(
    .DAC_WID(24), .STARVE_LIM(4), .STARVE_WID(3)
  ) dut (
    .clk(clk), .rst(rst),
    .arm_0(arm_0), .to_dac_0(to_dac_0), .ss_0(ss_0),
    .from_dac_0(from_dac_0), .finished_0(finished_0),
    .arm_1(arm_1), .to_dac_1(to_dac_1), .ss_1(ss_1),
    .from_dac_1(from_dac_1), .finished_1(finished_1),
    .master_arm(master_arm),
    .master_to_slave(master_to_slave),
    .master_ss(master_ss),
    .master_from_slave(master_from_slave),
    .master_finished(master_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int g,
                              input logic [23:0] w,
                              input int lat);
    exp_t e;
    e.g = g; e.w = w; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_arm"}, master_arm, 0);
    chk({tag, "_ss"}, master_ss, 0);
    chk({tag, "_fin"}, {finished_1, finished_0}, 0);
    chk({tag, "_rd0"}, from_dac_0, 0);
    chk({tag, "_rd1"}, from_dac_1, 0);
  endtask

  task automatic serve(input logic [23:0] rd, input bit done);
    exp_t e;
    int   n;
    bit   seen;
    e = sb.pop_front();
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n = i;
      seen = master_arm;
      if (seen) break;
    end
    chk("grant_seen", seen, 1);
    chk("grant_lat", n, e.lat);
    chk("grant_word", master_to_slave, e.w);
    chk("grant_ss", master_ss, (e.g == 1) ? ss_1 : ss_0);
    chk("fin_pre", {finished_1, finished_0}, 0);
    if (done) begin
      master_finished = 1'b1;
      master_from_slave = rd;
      #1;
      chk("fin_g", {finished_1, finished_0},
          (e.g == 1) ? 2'b10 : 2'b01);
      chk("rd_g", (e.g == 1) ? from_dac_1 : from_dac_0, rd);
      chk("rd_other", (e.g == 1) ? from_dac_0 : from_dac_1, 0);
    end
  endtask

  task automatic release_g(input int g, input bit rearm);
    if (g == 1) arm_1 = 1'b0;
    else arm_0 = 1'b0;
    @(negedge clk);
    all_zero("rel");
    master_finished = 1'b0;
    if (rearm) begin
      if (g == 1) arm_1 = 1'b1;
      else arm_0 = 1'b1;
    end
  endtask

  logic [23:0] w0, w1;

  initial begin
    rst = 1'b1;
    arm_0 = 0; arm_1 = 0; ss_0 = 1; ss_1 = 1;
    to_dac_0 = '0; to_dac_1 = '0;
    master_finished = 1'b1;
    master_from_slave = 24'h5A5A5A;
    #2;
    all_zero("rst0");
    chk("rst0_word", master_to_slave, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    master_finished = 1'b0;
    @(negedge clk);

    // single request from the control loop
    w0 = {DAC_REG_CODE, 20'hABCDE};
    arm_0 = 1; to_dac_0 = w0;
    expect_grant(0, w0, 1);
    serve(24'h123456, 1);
    release_g(0, 0);
    @(negedge clk);

    // simultaneous requests
    w1 = 24'h3CAFE1;
    arm_0 = 1; arm_1 = 1; to_dac_1 = w1;
    expect_grant(0, w0, 1);
    serve(24'h0F0F0F, 1);
    release_g(0, 0);
    expect_grant(1, w1, 2);
    serve(24'hF0F0F0, 1);
    release_g(1, 0);
    @(negedge clk);

    // starvation bound, two rounds to show the counter cleared
    arm_0 = 1; arm_1 = 1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        expect_grant(0, w0, (r == 0 && k == 0) ? 1 : 2);
        serve(24'h000100 + 24'(k), 1);
        release_g(0, 1);
      end
      expect_grant(1, w1, 2);
      serve(24'h00A000 + 24'(r), 1);
      if (r == 1) arm_0 = 0;
      release_g(1, r == 0);
    end
    @(negedge clk);

    // abort by requester 1 before the master finishes
    arm_1 = 1; to_dac_1 = 24'h3000AA;
    expect_grant(1, 24'h3000AA, 1);
    serve(24'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_fin1", finished_1, 0);
    arm_1 = 0;
    @(negedge clk);
    chk("abort_arm", master_arm, 0);
    master_finished = 1;
    arm_0 = 1; to_dac_0 = w0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_hold", master_arm, 0);
      chk("abort_fin", {finished_1, finished_0}, 0);
    end
    master_finished = 0;
    expect_grant(0, w0, 2);
    serve(24'h777777, 1);
    release_g(0, 0);
    @(negedge clk);

    // asynchronous reset in the middle of a grant
    arm_1 = 1; to_dac_1 = 24'h3BEEF0;
    expect_grant(1, 24'h3BEEF0, 1);
    serve(24'h246802, 1);
    #1 rst = 1;
    #1;
    all_zero("arst");
    chk("arst_word", master_to_slave, 0);
    @(negedge clk);
    chk("arst_hold", master_arm, 0);
    rst = 0;
    master_finished = 0;
    expect_grant(1, 24'h3BEEF0, 1);
    serve(24'h135790, 1);
    release_g(1, 0);
    @(negedge clk);

    // word latched at grant
    arm_0 = 1; to_dac_0 = 24'h200001;
    expect_grant(0, 24'h200001, 1);
    serve(24'h0, 0);
    to_dac_0 = 24'h2FFFFF;
    @(negedge clk);
    chk("latch_word", master_to_slave, 24'h200001);
    release_g(0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
